// File: rtl/systolic_pkg.sv
// Shared types, limits and the saturating/wrapping adder for the systolic PE.
package systolic_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ACC_W_DEF  = 40;
    // Widest accumulator the adder helper supports.
    localparam int unsigned ACC_W_MAX  = 64;

    typedef logic signed [DATA_W_DEF-1:0] data_t;
    typedef logic signed [ACC_W_DEF-1:0]  acc_t;
    typedef logic signed [ACC_W_MAX-1:0]  wide_t;

    localparam acc_t ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    // Adds two sign-extended values and fits the result into acc_w bits.
    // Returns {ovf, result sign-extended to ACC_W_MAX}.
    function automatic logic [ACC_W_MAX:0] sat_add(input wide_t       acc,
                                                   input wide_t       prod,
                                                   input int unsigned acc_w,
                                                   input logic        saturate);
        logic signed [ACC_W_MAX:0] sum, one_v, max_v, min_v, wrap_v, res;
        logic                      ovf;
        int unsigned               sh;
        one_v  = {{ACC_W_MAX{1'b0}}, 1'b1};
        sum    = {acc[ACC_W_MAX-1], acc} + {prod[ACC_W_MAX-1], prod};
        max_v  = (one_v <<< (acc_w - 1)) - one_v;
        min_v  = -max_v - one_v;
        sh     = ACC_W_MAX + 1 - acc_w;
        wrap_v = (sum <<< sh) >>> sh;
        ovf    = (sum > max_v) || (sum < min_v);
        if (!ovf) begin
            res = sum;
        end else if (saturate) begin
            res = (sum > max_v) ? max_v : min_v;
        end else begin
            res = wrap_v;
        end
        return {ovf, res[ACC_W_MAX-1:0]};
    endfunction

endpackage

// File: rtl/systolic_pe_mac.sv
// Multiplier, optional product register and saturating accumulate adder.
module pe_mac_unit
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ACC_W    = ACC_W_DEF,
    parameter int unsigned SATURATE = 1,
    parameter int unsigned MUL_PIPE = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     fire_i,
    input  logic                     first_i,
    input  logic                     last_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic                     commit_o,
    output logic                     first_o,
    output logic                     last_o,
    output logic                     ovf_o,
    output logic signed [ACC_W-1:0]  sum_o
);

    localparam int unsigned ProdW = 2 * DATA_W;

    logic signed [ProdW-1:0] prod_now, prod_q, prod_sel;
    logic                    valid_q, first_q, last_q;
    logic                    first_sel;
    wide_t                   base_w, prod_w;
    logic [ACC_W_MAX:0]      add_res;
    logic                    unused_hi;

    assign prod_now = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i})
                    * $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            prod_q  <= prod_now;
            valid_q <= fire_i;
            first_q <= first_i;
            last_q  <= last_i;
        end
    end

    // With MUL_PIPE the adder works on last cycle's product against the live accumulator.
    assign prod_sel  = (MUL_PIPE != 0) ? prod_q  : prod_now;
    assign first_sel = (MUL_PIPE != 0) ? first_q : first_i;
    assign commit_o  = (MUL_PIPE != 0) ? valid_q : fire_i;
    assign last_o    = (MUL_PIPE != 0) ? last_q  : last_i;
    assign first_o   = first_sel;

    assign prod_w = {{(ACC_W_MAX-ProdW){prod_sel[ProdW-1]}}, prod_sel};
    assign base_w = first_sel ? '0 : {{(ACC_W_MAX-ACC_W){acc_i[ACC_W-1]}}, acc_i};

    assign add_res   = sat_add(base_w, prod_w, ACC_W, SATURATE != 0);
    assign sum_o     = add_res[ACC_W-1:0];
    assign ovf_o     = add_res[ACC_W_MAX];
    assign unused_hi = ^add_res[ACC_W_MAX-1:ACC_W];

endmodule

// File: rtl/systolic_pe.sv
// Output-stationary PE: operand forwarding, accumulator, one-deep result slot, drain chain.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ACC_W    = ACC_W_DEF,
    parameter int unsigned SATURATE = 1,
    parameter int unsigned MUL_PIPE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic                     a_valid_in,
    input  logic                     first_in,
    input  logic                     last_in,
    input  logic signed [DATA_W-1:0] b_in,
    input  logic                     b_valid_in,
    output logic signed [DATA_W-1:0] a_out,
    output logic                     a_valid_out,
    output logic                     first_out,
    output logic                     last_out,
    output logic signed [DATA_W-1:0] b_out,
    output logic                     b_valid_out,
    input  logic signed [ACC_W-1:0]  drain_in,
    input  logic                     drain_valid_in,
    output logic signed [ACC_W-1:0]  drain_out,
    output logic                     drain_valid_out,
    output logic                     sat_flag,
    output logic                     drop_err
);

    logic signed [DATA_W-1:0] a_q, b_q;
    logic                     a_valid_q, b_valid_q, first_q, last_q;

    logic signed [ACC_W-1:0]  acc_q, acc_d, pend_val_q, pend_val_d, drain_q, drain_d;
    logic                     pend_q, pend_d, sat_q, sat_d, drop_q, drop_d;
    logic                     drain_valid_q, drain_valid_d;

    logic                     mac_commit, mac_first, mac_last, mac_ovf;
    logic signed [ACC_W-1:0]  mac_sum;

    pe_mac_unit #(
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .SATURATE(SATURATE),
        .MUL_PIPE(MUL_PIPE)
    ) u_mac (
        .clk_i   (clk),
        .rst_i   (rst),
        .fire_i  (a_valid_in & b_valid_in),
        .first_i (first_in),
        .last_i  (last_in),
        .a_i     (a_in),
        .b_i     (b_in),
        .acc_i   (acc_q),
        .commit_o(mac_commit),
        .first_o (mac_first),
        .last_o  (mac_last),
        .ovf_o   (mac_ovf),
        .sum_o   (mac_sum)
    );

    always_comb begin
        acc_d         = acc_q;
        sat_d         = sat_q;
        pend_d        = pend_q;
        pend_val_d    = pend_val_q;
        drop_d        = drop_q;
        drain_d       = drain_q;
        drain_valid_d = 1'b0;

        // Upstream traffic always wins; our own result waits in the slot.
        if (drain_valid_in) begin
            drain_d       = drain_in;
            drain_valid_d = 1'b1;
        end else if (pend_q) begin
            drain_d       = pend_val_q;
            drain_valid_d = 1'b1;
            pend_d        = 1'b0;
        end

        if (mac_commit) begin
            acc_d = mac_sum;
            sat_d = (mac_first ? 1'b0 : sat_q) | mac_ovf;
            // A slot freed on this same edge can take the new result.
            if (mac_last) begin
                if (pend_d) begin
                    drop_d = 1'b1;
                end else begin
                    pend_d     = 1'b1;
                    pend_val_d = mac_sum;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q           <= '0;
            b_q           <= '0;
            a_valid_q     <= 1'b0;
            b_valid_q     <= 1'b0;
            first_q       <= 1'b0;
            last_q        <= 1'b0;
            acc_q         <= '0;
            sat_q         <= 1'b0;
            pend_q        <= 1'b0;
            pend_val_q    <= '0;
            drop_q        <= 1'b0;
            drain_q       <= '0;
            drain_valid_q <= 1'b0;
        end else begin
            a_q           <= a_in;
            b_q           <= b_in;
            a_valid_q     <= a_valid_in;
            b_valid_q     <= b_valid_in;
            first_q       <= first_in;
            last_q        <= last_in;
            acc_q         <= acc_d;
            sat_q         <= sat_d;
            pend_q        <= pend_d;
            pend_val_q    <= pend_val_d;
            drop_q        <= drop_d;
            drain_q       <= drain_d;
            drain_valid_q <= drain_valid_d;
        end
    end

    assign a_out           = a_q;
    assign b_out           = b_q;
    assign a_valid_out     = a_valid_q;
    assign b_valid_out     = b_valid_q;
    assign first_out       = first_q;
    assign last_out        = last_q;
    assign drain_out       = drain_q;
    assign drain_valid_out = drain_valid_q;
    assign sat_flag        = sat_q;
    assign drop_err        = drop_q;

endmodule

// File: tb/tb_systolic_pe.sv
// Bench for systolic_pe: four parameterisations share one stimulus stream, checked vs a model.
module tb_systolic_pe;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] a_in = '0, b_in = '0;
    logic               a_valid_in = 0, b_valid_in = 0, first_in = 0, last_in = 0;
    logic               drain_valid_in = 0;
    logic signed [39:0] drain_in = '0;

    logic signed [15:0] ao[4], bo[4];
    logic               avo[4], bvo[4], fo[4], lo[4], dvo[4], sat[4], drp[4];
    logic signed [39:0] do40[2];
    logic signed [31:0] do32[2];

    int n_tests = 0;
    int n_fail  = 0;

    // DUT 0: 40b sat, 1: 32b sat, 2: 32b wrap, 3: 40b sat with product pipeline
    int     m_w[4]    = '{40, 32, 32, 40};
    bit     m_satm[4] = '{1, 1, 0, 1};
    bit     m_pipe[4] = '{0, 0, 0, 1};
    longint m_acc[4], m_pval[4], m_dout[4], m_sp[4];
    bit     m_flag[4], m_pend[4], m_drop[4], m_dv[4], m_sv[4], m_sf[4], m_sl[4];

    always #5 clk = ~clk;

    systolic_pe #(.DATA_W(16), .ACC_W(40), .SATURATE(1), .MUL_PIPE(0)) u_dut0 (
        .clk(clk), .rst(rst), .a_in(a_in), .a_valid_in(a_valid_in), .first_in(first_in),
        .last_in(last_in), .b_in(b_in), .b_valid_in(b_valid_in), .a_out(ao[0]),
        .a_valid_out(avo[0]), .first_out(fo[0]), .last_out(lo[0]), .b_out(bo[0]),
        .b_valid_out(bvo[0]), .drain_in(drain_in), .drain_valid_in(drain_valid_in),
        .drain_out(do40[0]), .drain_valid_out(dvo[0]), .sat_flag(sat[0]), .drop_err(drp[0]));

    systolic_pe #(.DATA_W(16), .ACC_W(32), .SATURATE(1), .MUL_PIPE(0)) u_dut1 (
        .clk(clk), .rst(rst), .a_in(a_in), .a_valid_in(a_valid_in), .first_in(first_in),
        .last_in(last_in), .b_in(b_in), .b_valid_in(b_valid_in), .a_out(ao[1]),
        .a_valid_out(avo[1]), .first_out(fo[1]), .last_out(lo[1]), .b_out(bo[1]),
        .b_valid_out(bvo[1]), .drain_in(drain_in[31:0]), .drain_valid_in(drain_valid_in),
        .drain_out(do32[0]), .drain_valid_out(dvo[1]), .sat_flag(sat[1]), .drop_err(drp[1]));

    systolic_pe #(.DATA_W(16), .ACC_W(32), .SATURATE(0), .MUL_PIPE(0)) u_dut2 (
        .clk(clk), .rst(rst), .a_in(a_in), .a_valid_in(a_valid_in), .first_in(first_in),
        .last_in(last_in), .b_in(b_in), .b_valid_in(b_valid_in), .a_out(ao[2]),
        .a_valid_out(avo[2]), .first_out(fo[2]), .last_out(lo[2]), .b_out(bo[2]),
        .b_valid_out(bvo[2]), .drain_in(drain_in[31:0]), .drain_valid_in(drain_valid_in),
        .drain_out(do32[1]), .drain_valid_out(dvo[2]), .sat_flag(sat[2]), .drop_err(drp[2]));

    systolic_pe #(.DATA_W(16), .ACC_W(40), .SATURATE(1), .MUL_PIPE(1)) u_dut3 (
        .clk(clk), .rst(rst), .a_in(a_in), .a_valid_in(a_valid_in), .first_in(first_in),
        .last_in(last_in), .b_in(b_in), .b_valid_in(b_valid_in), .a_out(ao[3]),
        .a_valid_out(avo[3]), .first_out(fo[3]), .last_out(lo[3]), .b_out(bo[3]),
        .b_valid_out(bvo[3]), .drain_in(drain_in), .drain_valid_in(drain_valid_in),
        .drain_out(do40[1]), .drain_valid_out(dvo[3]), .sat_flag(sat[3]), .drop_err(drp[3]));

    function automatic longint drain_of(input int d);
        case (d)
            0:       return longint'(do40[0]);
            1:       return longint'(do32[0]);
            2:       return longint'(do32[1]);
            default: return longint'(do40[1]);
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            m_acc[d] = 0; m_pval[d] = 0; m_dout[d] = 0; m_sp[d] = 0;
            m_flag[d] = 0; m_pend[d] = 0; m_drop[d] = 0; m_dv[d] = 0;
            m_sv[d] = 0; m_sf[d] = 0; m_sl[d] = 0;
        end
    endtask

    // Behaviour of one clock edge, written from the arithmetic rules of the PE.
    task automatic model_step();
        bit     fire, c, cf, cl, ovf;
        longint np, p, s, lim, v;
        fire = a_valid_in && b_valid_in;
        np   = longint'(a_in) * longint'(b_in);
        for (int d = 0; d < 4; d++) begin
            if (m_pipe[d]) begin
                c = m_sv[d]; p = m_sp[d]; cf = m_sf[d]; cl = m_sl[d];
                m_sv[d] = fire; m_sp[d] = np; m_sf[d] = first_in; m_sl[d] = last_in;
            end else begin
                c = fire; p = np; cf = first_in; cl = last_in;
            end
            if (drain_valid_in) begin
                m_dout[d] = longint'(drain_in); m_dv[d] = 1;
            end else if (m_pend[d]) begin
                m_dout[d] = m_pval[d]; m_dv[d] = 1; m_pend[d] = 0;
            end else begin
                m_dv[d] = 0;
            end
            if (c) begin
                s   = (cf ? 64'sd0 : m_acc[d]) + p;
                lim = longint'(1) <<< (m_w[d] - 1);
                ovf = (s >= lim) || (s < -lim);
                if (!ovf) v = s;
                else if (m_satm[d]) v = (s > 0) ? lim - 1 : -lim;
                else begin
                    v = s & (2 * lim - 1);
                    if (v >= lim) v = v - 2 * lim;
                end
                m_acc[d]  = v;
                m_flag[d] = (cf ? 1'b0 : m_flag[d]) | ovf;
                if (cl) begin
                    if (m_pend[d]) m_drop[d] = 1;
                    else begin m_pend[d] = 1; m_pval[d] = v; end
                end
            end
        end
    endtask

    task automatic step(input bit av, input logic signed [15:0] a, input bit bv,
                        input logic signed [15:0] b, input bit f, input bit l,
                        input bit dv, input longint din);
        a_valid_in = av; a_in = a; b_valid_in = bv; b_in = b;
        first_in = f; last_in = l; drain_valid_in = dv; drain_in = din[39:0];
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        step(0, 16'sd0, 0, 16'sd0, 0, 0, 0, 0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        a_valid_in = 0; b_valid_in = 0; first_in = 0; last_in = 0; drain_valid_in = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        step(1, 16'sd2, 1, 16'sd3, 1, 0, 0, 0);
        step(1, 16'sd2, 1, 16'sd3, 0, 0, 0, 0);
        step(1, 16'sd2, 1, 16'sd3, 0, 0, 0, 0);
        n_tests++;
        if (dvo[0] !== 1'b0 || ao[0] !== 16'sd2) begin
            n_fail++;
            $display("FAIL reset_pre: valid %b a_out %0d, want 0 and 2", dvo[0], ao[0]);
        end
        rst = 1'b1;
        a_valid_in = 0; b_valid_in = 0; first_in = 0;
        #1;
        for (int d = 0; d < 4; d++) begin
            n_tests++;
            if (dvo[d] !== 1'b0 || sat[d] !== 1'b0 || drp[d] !== 1'b0 || ao[d] !== 16'sd0 ||
                avo[d] !== 1'b0 || bo[d] !== 16'sd0 || drain_of(d) != 0) begin
                n_fail++;
                $display("FAIL reset_async dut%0d: dv %b sat %b drop %b a_out %0d drain %0d, want all 0",
                         d, dvo[d], sat[d], drp[d], ao[d], drain_of(d));
            end
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 16'sd4, 1, 16'sd5, 1, 1, 0, 0);
        n_tests++;
        if (dvo[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_early_drain: valid %b, want 0", dvo[0]);
        end
        idle();
        n_tests++;
        if (dvo[0] !== 1'b1 || drain_of(0) != 20 || dvo[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tile: dut0 valid %b drain %0d, dut3 valid %b; want 1, 20, 0",
                     dvo[0], drain_of(0), dvo[3]);
        end
        idle();
        n_tests++;
        if (dvo[3] !== 1'b1 || drain_of(3) != 20 || sat[0] !== 1'b0 || drp[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tile_pipe: valid %b drain %0d sat %b drop %b, want 1 20 0 0",
                     dvo[3], drain_of(3), sat[0], drp[0]);
        end
    endtask

    task automatic test_dot_product();
        reset_dut();
        step(1, 16'sd1, 1, 16'sd2, 1, 0, 0, 0);
        n_tests++;
        if (ao[0] !== 16'sd1 || bo[0] !== 16'sd2 || fo[0] !== 1'b1 || avo[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL dot_fwd1: a_out %0d b_out %0d first %b, want 1 2 1", ao[0], bo[0], fo[0]);
        end
        step(1, -16'sd3, 1, 16'sd4, 0, 0, 0, 0);
        step(1, 16'sd5, 1, 16'sd6, 0, 1, 0, 0);
        n_tests++;
        if (ao[0] !== 16'sd5 || bo[0] !== 16'sd6 || lo[0] !== 1'b1 || fo[0] !== 1'b0 ||
            dvo[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL dot_fwd3: a_out %0d b_out %0d last %b dv %b, want 5 6 1 0",
                     ao[0], bo[0], lo[0], dvo[0]);
        end
        idle();
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (dvo[d] !== 1'b1 || drain_of(d) != 20) begin
                n_fail++;
                $display("FAIL dot_drain dut%0d: valid %b drain %0d, want 1 20", d, dvo[d], drain_of(d));
            end
        end
        idle();
        n_tests++;
        if (dvo[0] !== 1'b0 || drain_of(0) != 20) begin
            n_fail++;
            $display("FAIL dot_hold: valid %b drain %0d, want 0 20", dvo[0], drain_of(0));
        end
    endtask

    task automatic test_saturation();
        reset_dut();
        step(1, 16'sd32767, 1, 16'sd32767, 1, 0, 0, 0);
        step(1, 16'sd32767, 1, 16'sd32767, 0, 0, 0, 0);
        n_tests++;
        if (sat[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_early: sat_flag %b, want 0", sat[1]);
        end
        step(1, 16'sd32767, 1, 16'sd32767, 0, 1, 0, 0);
        n_tests++;
        if (sat[1] !== 1'b1 || sat[2] !== 1'b1 || sat[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_flag: sat32 %b wrap32 %b wide %b, want 1 1 0", sat[1], sat[2], sat[0]);
        end
        step(1, 16'sd1, 1, 16'sd1, 1, 1, 0, 0);
        n_tests++;
        if (dvo[1] !== 1'b1 || drain_of(1) != 64'sd2147483647) begin
            n_fail++;
            $display("FAIL sat_clamp: valid %b drain %0d, want 1 2147483647", dvo[1], drain_of(1));
        end
        n_tests++;
        if (drain_of(2) != -64'sd1073938429 || drain_of(0) != 64'sd3221028867) begin
            n_fail++;
            $display("FAIL sat_wrap: wrap %0d wide %0d, want -1073938429 3221028867",
                     drain_of(2), drain_of(0));
        end
        n_tests++;
        if (sat[1] !== 1'b0 || sat[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_clear: sat32 %b wrap32 %b, want 0 0", sat[1], sat[2]);
        end
        idle();
        n_tests++;
        if (dvo[1] !== 1'b1 || drain_of(1) != 1 || drp[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_next_tile: valid %b drain %0d drop %b, want 1 1 0",
                     dvo[1], drain_of(1), drp[1]);
        end
    endtask

    task automatic test_drain_priority();
        longint fwd[3] = '{100, -200, 300};
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            step(i == 0, 16'sd7, i == 0, 16'sd3, i == 0, i == 0, 1, fwd[i]);
            n_tests++;
            if (dvo[0] !== 1'b1 || drain_of(0) != fwd[i] || dvo[3] !== 1'b1) begin
                n_fail++;
                $display("FAIL prio_fwd%0d: valid %b drain %0d, want 1 %0d",
                         i, dvo[0], drain_of(0), fwd[i]);
            end
        end
        idle();
        for (int d = 0; d < 4; d += 3) begin
            n_tests++;
            if (dvo[d] !== 1'b1 || drain_of(d) != 21 || drp[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL prio_own dut%0d: valid %b drain %0d drop %b, want 1 21 0",
                         d, dvo[d], drain_of(d), drp[d]);
            end
        end
        idle();
        n_tests++;
        if (dvo[0] !== 1'b0 || drain_of(0) != 21) begin
            n_fail++;
            $display("FAIL prio_after: valid %b drain %0d, want 0 21", dvo[0], drain_of(0));
        end
    endtask

    task automatic test_overflow_drop();
        reset_dut();
        step(1, 16'sd2, 1, 16'sd2, 1, 1, 1, 11);
        n_tests++;
        if (drp[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_early: drop_err %b, want 0", drp[0]);
        end
        step(1, 16'sd3, 1, 16'sd3, 1, 1, 1, 12);
        n_tests++;
        if (drp[0] !== 1'b1 || drp[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_set: dut0 %b dut3 %b, want 1 0", drp[0], drp[3]);
        end
        step(0, 16'sd0, 0, 16'sd0, 0, 0, 1, 13);
        n_tests++;
        if (drp[3] !== 1'b1 || drain_of(0) != 13) begin
            n_fail++;
            $display("FAIL drop_pipe: drop %b drain %0d, want 1 13", drp[3], drain_of(0));
        end
        idle();
        for (int d = 0; d < 4; d += 3) begin
            n_tests++;
            if (dvo[d] !== 1'b1 || drain_of(d) != 4 || drp[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL drop_keep dut%0d: valid %b drain %0d drop %b, want 1 4 1",
                         d, dvo[d], drain_of(d), drp[d]);
            end
        end
        idle();
        n_tests++;
        if (dvo[0] !== 1'b0 || drp[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_sticky: valid %b drop %b, want 0 1", dvo[0], drp[0]);
        end
    endtask

    task automatic test_valid_gating_pipe();
        reset_dut();
        step(1, 16'sd1,  1, 16'sd2, 1, 0, 0, 0);
        step(0, 16'sd9,  1, 16'sd9, 0, 0, 0, 0);
        step(1, 16'sd9,  0, 16'sd9, 0, 0, 0, 0);
        step(1, -16'sd3, 1, 16'sd4, 0, 0, 0, 0);
        step(0, 16'sd0,  0, 16'sd0, 0, 0, 0, 0);
        step(1, 16'sd5,  1, 16'sd6, 0, 1, 0, 0);
        idle();
        n_tests++;
        if (dvo[0] !== 1'b1 || drain_of(0) != 20 || dvo[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL gate_nopipe: valid %b drain %0d pipe valid %b, want 1 20 0",
                     dvo[0], drain_of(0), dvo[3]);
        end
        idle();
        n_tests++;
        if (dvo[3] !== 1'b1 || drain_of(3) != 20) begin
            n_fail++;
            $display("FAIL gate_pipe: valid %b drain %0d, want 1 20", dvo[3], drain_of(3));
        end
    endtask

    task automatic test_random();
        logic signed [15:0] ra, rb, pa, pb;
        bit                 rav, rbv, rf, rl, rdv, pav, pbv, pf, pl;
        longint             rd;
        reset_dut();
        pa = 0; pb = 0; pav = 0; pbv = 0; pf = 0; pl = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            ra  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 200)) - 16'sd100
                                              : 16'($urandom);
            rb  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 200)) - 16'sd100
                                              : 16'($urandom);
            rav = $urandom_range(0, 3) != 0;
            rbv = $urandom_range(0, 3) != 0;
            rf  = $urandom_range(0, 5) == 0;
            rl  = $urandom_range(0, 5) == 0;
            rdv = $urandom_range(0, 4) == 0;
            rd  = longint'($urandom_range(0, 32'h4000_0000)) - 64'sh2000_0000;
            step(rav, ra, rbv, rb, rf, rl, rdv, rd);
            for (int d = 0; d < 4; d++) begin
                n_tests++;
                if (dvo[d] !== m_dv[d] || drain_of(d) != m_dout[d] || sat[d] !== m_flag[d] ||
                    drp[d] !== m_drop[d]) begin
                    n_fail++;
                    $display("FAIL rand c%0d dut%0d: dv %b out %0d sat %b drop %b, want %b %0d %b %b",
                             cyc, d, dvo[d], drain_of(d), sat[d], drp[d],
                             m_dv[d], m_dout[d], m_flag[d], m_drop[d]);
                end
            end
            n_tests++;
            if (ao[3] !== ra || bo[3] !== rb || avo[3] !== rav || bvo[3] !== rbv ||
                fo[3] !== rf || lo[3] !== rl) begin
                n_fail++;
                $display("FAIL rand_fwd c%0d: a %0d b %0d, want %0d %0d", cyc, ao[3], bo[3], ra, rb);
            end
            pa = ra; pb = rb; pav = rav; pbv = rbv; pf = rf; pl = rl;
        end
        n_tests++;
        if (ao[0] !== pa || bo[0] !== pb || avo[0] !== pav || bvo[0] !== pbv ||
            fo[0] !== pf || lo[0] !== pl) begin
            n_fail++;
            $display("FAIL rand_fwd_last: a %0d b %0d, want %0d %0d", ao[0], bo[0], pa, pb);
        end
    endtask

    initial begin
        model_reset();
        #2;
        test_reset();
        test_dot_product();
        test_saturation();
        test_drain_priority();
        test_overflow_drop();
        test_valid_gating_pipe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_pe.md
Name: systolic_pe

Overview:
Second-generation output-stationary processing element for the systolic matrix-multiply array. Operands flow east (a) and south (b), each with a valid bit; the accumulator is signed and optionally saturating. Tile boundaries are marked by first/last flags. Finished results leave through a north-to-south drain chain, so no per-PE output bus is needed. Instantiated in an R x C grid by the array top.

Parameters:
DATA_W, 16, signed operand width
ACC_W, 40, signed accumulator width; must be >= 2*DATA_W
SATURATE, 1, 1 = clamp the accumulator on overflow; 0 = two's-complement wrap
MUL_PIPE, 0, 0 = multiply and accumulate in one stage; 1 = product registered first, accumulate one cycle later

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
a_in  in  DATA_W  signed operand from west
a_valid_in  in  1  a_in valid
first_in  in  1  first MAC of tile; travels with a
last_in  in  1  last MAC of tile; travels with a
b_in  in  DATA_W  signed operand from north
b_valid_in  in  1  b_in valid
a_out, a_valid_out, first_out, last_out  out  DATA_W,1,1,1  registered copies to east
b_out, b_valid_out  out  DATA_W,1  registered copies to south
drain_in  in  ACC_W  result from north neighbour's drain
drain_valid_in  in  1  drain_in valid
drain_out  out  ACC_W  drain to south
drain_valid_out  out  1  drain_out valid
sat_flag  out  1  sticky: saturation/wrap occurred in current tile
drop_err  out  1  sticky: a result was lost (pending slot busy)

Behaviour:
- Reset (async, immediate): all outputs 0; accumulator, pending slot and pipeline registers 0. Reset mid-tile discards the partial sum and any pending result.
- Forwarding: every cycle, a/a_valid/first/last and b/b_valid are registered to the *_out ports (1-cycle latency), independent of MAC state.
- MAC fires when a_valid_in & b_valid_in. If only one valid is set, there is no MAC; forwarding continues.
- Product: signed DATA_W x DATA_W gives 2*DATA_W bits, sign-extended to ACC_W.
- Sum: base = first ? 0 : acc; sum = base + product, computed at ACC_W+1 bits.
- Overflow with SATURATE=1: clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1). With SATURATE=0: wrap.
- sat_flag on overflow: set on either setting. A MAC with first=1 clears it, then ORs in its own overflow.
- Commit timing: MUL_PIPE=0 commits at the capturing edge. MUL_PIPE=1 registers product, first and last at edge N and commits at edge N+1.
- first=1 and last=1 on the same MAC: result = product (saturated/wrapped as above).
- Completion: a committing MAC with last=1 writes the committed value into the pending slot and sets pending.
- Pending slot already full when a new result arrives: keep the older result, drop the new one, set drop_err. drop_err clears only on reset.
- Drain mux, each edge:
  - drain_valid_in=1: forward drain_in to drain_out with valid=1; pending holds.
  - Else if pending: send the result, valid=1, clear pending.
  - Else: valid=0 and drain_out holds its last value.
- Upstream drain traffic always has priority; the chain never stalls.
- Earliest drain: result visible on drain_out one cycle after the completion edge.
- Accumulator holds its value when no MAC fires. No clear is needed between tiles because first resets the base.

Decomposition:
- Package systolic_pkg:
  - types data_t and acc_t, parameterised through package localparams DATA_W_DEF and ACC_W_DEF
  - constants ACC_MAX and ACC_MIN
  - function sat_add(acc, prod, saturate) returning {ovf, sum}
- Sub-module pe_mac_unit: multiplier, optional product register, saturating adder, sat detect.
- systolic_pe keeps forwarding registers, accumulator, pending slot and drain mux.

Test Plan:
- Reset mid-tile: 3 MACs of 2x3, assert rst, then one MAC with first=last=1 of 4x5 → drain_out=20, no earlier value ever drained, both flags 0.
- Dot product, MUL_PIPE=0: pairs (1,2),(−3,4),(5,6), first on pair 1, last on pair 3 → drain_out=20 one cycle after the last edge; a_out/b_out each echo inputs 1 cycle later.
- Saturation: ACC_W=32, DATA_W=16, 3 MACs of 32767 x 32767 → +2^31−1 with sat_flag=1. Next tile with first and 1x1 → 1 and sat_flag=0. SATURATE=0 run → wrapped value.
- Drain priority: pending set while drain_valid_in high for 3 cycles → 3 forwarded values, then own result on cycle 4; nothing lost, drop_err=0.
- Overflow drop: second last-commit while pending is blocked by a continuous drain_valid_in → first result drained later, second lost, drop_err=1.
- Valid gating plus MUL_PIPE=1: a_valid only on some cycles → no accumulation there; the same tile as the dot-product test yields 20, one cycle later than MUL_PIPE=0.
